// File: rtl/slots_pkg.sv
// Shared definitions for the slot-machine reel logic.
//   SYM_W      : width of one reel symbol
//   CNT_W      : width of the per-reel spin counter
//   state_e    : reel controller FSM states
//   RES_*      : encodings of the match result (3 is never produced)
package slots_pkg;

    localparam int SYM_W = 3;
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SPIN0 = 3'd1,
        SPIN1 = 3'd2,
        SPIN2 = 3'd3,
        EVAL  = 3'd4
    } state_e;

    localparam logic [1:0] RES_NONE   = 2'd0;
    localparam logic [1:0] RES_PAIR   = 2'd1;
    localparam logic [1:0] RES_TRIPLE = 2'd2;

endpackage

// File: rtl/reel_controller_if.sv
// Request/display bundle between the player-side logic and the reel controller.
//   spin   : spin request (master -> slave)
//   rnd    : random symbol, valid every cycle (master -> slave)
//   reel0/1/2 : displayed symbols (slave -> master)
//   busy   : spin in progress (slave -> master)
//   done   : one-cycle pulse when the result is final (slave -> master)
//   result : match result, see RES_* in slots_pkg (slave -> master)
interface reel_controller_if;
    import slots_pkg::*;

    logic             spin;
    logic [SYM_W-1:0] rnd;
    logic [SYM_W-1:0] reel0;
    logic [SYM_W-1:0] reel1;
    logic [SYM_W-1:0] reel2;
    logic             busy;
    logic             done;
    logic [1:0]       result;

    modport master (
        output spin, rnd,
        input  reel0, reel1, reel2, busy, done, result
    );

    modport slave (
        input  spin, rnd,
        output reel0, reel1, reel2, busy, done, result
    );

endinterface

// File: rtl/reel_match.sv
// Combinational match evaluation of three reel symbols.
//   sym_a/b/c : the three final reel symbols
//   result    : RES_TRIPLE if all equal, RES_PAIR if exactly two equal,
//               otherwise RES_NONE
module reel_match
    import slots_pkg::*;
(
    input  logic [SYM_W-1:0] sym_a,
    input  logic [SYM_W-1:0] sym_b,
    input  logic [SYM_W-1:0] sym_c,
    output logic [1:0]       result
);

    // Classify the symbol triple by how many reels agree.
    always_comb begin
        result = RES_NONE;
        if ((sym_a == sym_b) && (sym_b == sym_c)) begin
            result = RES_TRIPLE;
        end else if ((sym_a == sym_b) || (sym_b == sym_c) || (sym_a == sym_c)) begin
            result = RES_PAIR;
        end else begin
            result = RES_NONE;
        end
    end

endmodule

// File: rtl/reel_controller.sv
// Three-reel slot controller. A spin request in IDLE starts the reels; each
// reel spins for SPIN_CYCLES edges (reels to its right keep spinning with it),
// then stops in turn. One evaluation edge after the last reel stops, the
// match result is registered and done pulses for one cycle.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : slave side of reel_controller_if (spin/rnd in; reels/busy/done/result out)
module reel_controller
    import slots_pkg::*;
#(
    parameter int SPIN_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    reel_controller_if.slave bus
);

    // Counter value on the last edge of a reel's spin.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPIN_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SYM_W-1:0] reel0_q, reel0_d;
    logic [SYM_W-1:0] reel1_q, reel1_d;
    logic [SYM_W-1:0] reel2_q, reel2_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       result_q, result_d;
    logic [1:0]       match_res_s;
    logic             cnt_last_s;

    assign cnt_last_s = (cnt_q == CNT_LAST);

    reel_match u_match (
        .sym_a  (reel0_q),
        .sym_b  (reel1_q),
        .sym_c  (reel2_q),
        .result (match_res_s)
    );

    // Next-state, counter, reel and status computation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reel0_d  = reel0_q;
        reel1_d  = reel1_q;
        reel2_d  = reel2_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (bus.spin) begin
                    state_d  = SPIN0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    result_d = RES_NONE;
                end else begin
                    state_d = IDLE;
                end
            end
            // Each spinning stage drives its own reel and every reel to its right.
            SPIN0: begin
                reel0_d = bus.rnd;
                reel1_d = bus.rnd;
                reel2_d = bus.rnd;
                if (cnt_last_s) begin
                    cnt_d   = '0;
                    state_d = SPIN1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SPIN1: begin
                reel1_d = bus.rnd;
                reel2_d = bus.rnd;
                if (cnt_last_s) begin
                    cnt_d   = '0;
                    state_d = SPIN2;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SPIN2: begin
                reel2_d = bus.rnd;
                if (cnt_last_s) begin
                    cnt_d   = '0;
                    state_d = EVAL;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            EVAL: begin
                result_d = match_res_s;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            reel0_q  <= '0;
            reel1_q  <= '0;
            reel2_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= RES_NONE;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reel0_q  <= reel0_d;
            reel1_q  <= reel1_d;
            reel2_q  <= reel2_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign bus.reel0  = reel0_q;
    assign bus.reel1  = reel1_q;
    assign bus.reel2  = reel2_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_reel_controller.sv
// Bench for reel_controller: two instances (SPIN_CYCLES 4 and 1) checked every
// cycle against a transaction-level model, plus directed literal checks.
module tb_reel_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       spin_s [2];
    logic [2:0] rnd_s  [2];
    logic       rand1;
    logic       cmp_en;
    int         n_checks = 0;
    int         n_pass   = 0;

    reel_controller_if if4 ();
    reel_controller_if if1 ();

    assign if4.spin = spin_s[0];
    assign if4.rnd  = rnd_s[0];
    assign if1.spin = spin_s[1];
    assign if1.rnd  = rnd_s[1];

    reel_controller #(.SPIN_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    reel_controller #(.SPIN_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    logic [2:0] o_r0 [2];
    logic [2:0] o_r1 [2];
    logic [2:0] o_r2 [2];
    logic       o_busy [2];
    logic       o_done [2];
    logic [1:0] o_res [2];

    assign o_r0[0] = if4.reel0;  assign o_r0[1] = if1.reel0;
    assign o_r1[0] = if4.reel1;  assign o_r1[1] = if1.reel1;
    assign o_r2[0] = if4.reel2;  assign o_r2[1] = if1.reel2;
    assign o_busy[0] = if4.busy; assign o_busy[1] = if1.busy;
    assign o_done[0] = if4.done; assign o_done[1] = if1.done;
    assign o_res[0] = if4.result; assign o_res[1] = if1.result;

    // Model: k counts edges since the spin was accepted; reels settle by
    // edge range, result appears at edge 3S+1.
    typedef struct packed {
        logic        busy;
        logic [15:0] k;
        logic [2:0]  r0;
        logic [2:0]  r1;
        logic [2:0]  r2;
        logic        done;
        logic [1:0]  res;
    } mdl_t;

    mdl_t m [2];

    function automatic logic [1:0] classify(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        int eq;
        eq = int'(a == b) + int'(b == c) + int'(a == c);
        if (eq == 3) return 2'd2;
        if (eq == 1) return 2'd1;
        return 2'd0;
    endfunction

    function automatic mdl_t mdl_next(input mdl_t cur, input logic sp, input logic [2:0] r, input int s);
        mdl_t n;
        n = cur;
        n.done = 1'b0;
        if (!cur.busy) begin
            if (sp) begin
                n.busy = 1'b1;
                n.k    = 16'd0;
                n.res  = 2'd0;
            end
        end else begin
            n.k = cur.k + 16'd1;
            if (int'(n.k) <= s) begin
                n.r0 = r; n.r1 = r; n.r2 = r;
            end else if (int'(n.k) <= 2 * s) begin
                n.r1 = r; n.r2 = r;
            end else if (int'(n.k) <= 3 * s) begin
                n.r2 = r;
            end else begin
                n.res  = classify(cur.r0, cur.r1, cur.r2);
                n.done = 1'b1;
                n.busy = 1'b0;
            end
        end
        return n;
    endfunction

    // Model state update, cleared asynchronously like the design.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m[0] <= '0;
            m[1] <= '0;
        end else begin
            m[0] <= mdl_next(m[0], spin_s[0], rnd_s[0], 4);
            m[1] <= mdl_next(m[1], spin_s[1], rnd_s[1], 1);
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if ({o_r0[i], o_r1[i], o_r2[i], o_busy[i], o_done[i], o_res[i]} ===
                    {m[i].r0, m[i].r1, m[i].r2, m[i].busy, m[i].done, m[i].res}) begin
                    n_pass++;
                end else begin
                    $display("FAIL model_cmp dut%0d t=%0t got reels=%0d,%0d,%0d busy=%b done=%b res=%0d want reels=%0d,%0d,%0d busy=%b done=%b res=%0d",
                             i, $time, o_r0[i], o_r1[i], o_r2[i], o_busy[i], o_done[i], o_res[i],
                             m[i].r0, m[i].r1, m[i].r2, m[i].busy, m[i].done, m[i].res);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand1) begin
            spin_s[1] = ($urandom_range(0, 2) == 0);
            rnd_s[1]  = 3'($urandom_range(0, 7));
        end
    endtask

    // One S=4 spin: rnd=a on edges 1..4, b on 5..8, c from 9 on.
    task automatic run_spin4(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                             input bit extra, input int exp_res, input string tag);
        int n_done;
        int done_edge;
        n_done = 0;
        done_edge = -1;
        spin_s[0] = 1'b1;
        rnd_s[0]  = a;
        tick();
        for (int e = 1; e <= 16; e++) begin
            rnd_s[0]  = (e <= 4) ? a : ((e <= 8) ? b : c);
            spin_s[0] = extra && ((e == 3) || (e == 10));
            tick();
            check({tag, "_busy"}, int'(if4.busy), int'(e <= 12));
            if (if4.done) begin
                n_done++;
                done_edge = e;
            end
        end
        spin_s[0] = 1'b0;
        check({tag, "_reel0"}, int'(if4.reel0), int'(a));
        check({tag, "_reel1"}, int'(if4.reel1), int'(b));
        check({tag, "_reel2"}, int'(if4.reel2), int'(c));
        check({tag, "_result"}, int'(if4.result), exp_res);
        check({tag, "_n_done"}, n_done, 1);
        check({tag, "_done_edge"}, done_edge, 13);
    endtask

    initial begin
        int guard;
        int n_done;
        rst = 1'b1;
        cmp_en = 1'b0;
        rand1 = 1'b1;
        spin_s[0] = 1'b0; spin_s[1] = 1'b0;
        rnd_s[0] = 3'd0;  rnd_s[1] = 3'd0;
        #2 rst = 1'b0;
        #1;
        check("reset_reel0", int'(if4.reel0), 0);
        check("reset_reel2", int'(if4.reel2), 0);
        check("reset_busy", int'(if4.busy), 0);
        check("reset_done", int'(if4.done), 0);
        check("reset_result", int'(if4.result), 0);
        check("reset_busy1", int'(if1.busy), 0);
        cmp_en = 1'b1;
        @(posedge clk);
        #3 rst = 1'b1;

        run_spin4(3'd5, 3'd5, 3'd5, 1'b0, 2, "triple");
        run_spin4(3'd1, 3'd2, 3'd1, 1'b0, 1, "pair");
        run_spin4(3'd1, 3'd2, 3'd3, 1'b0, 0, "none");
        run_spin4(3'd6, 3'd6, 3'd3, 1'b1, 1, "ignore_spin");

        // Abort during SPIN1 with an asynchronous reset.
        spin_s[0] = 1'b1;
        rnd_s[0]  = 3'd4;
        tick();
        spin_s[0] = 1'b0;
        for (int e = 1; e <= 6; e++) tick();
        #2 rst = 1'b0;
        #1;
        check("abort_reel1", int'(if4.reel1), 0);
        check("abort_busy", int'(if4.busy), 0);
        check("abort_done", int'(if4.done), 0);
        #3 rst = 1'b1;
        n_done = 0;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (if4.done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        run_spin4(3'd7, 3'd7, 3'd7, 1'b0, 2, "after_abort");

        // S=1 back-to-back spins with spin held high.
        rand1 = 1'b0;
        spin_s[1] = 1'b0;
        guard = 0;
        while (if1.busy && guard < 20) begin
            tick();
            guard++;
        end
        check("s1_idle_wait", int'(if1.busy), 0);
        spin_s[1] = 1'b1;
        rnd_s[1]  = 3'd0;
        tick();
        for (int e = 1; e <= 24; e++) begin
            rnd_s[1] = 3'(e);
            tick();
            check("s1_done", int'(if1.done), int'((e % 5) == 4));
            check("s1_busy", int'(if1.busy), int'((e % 5) != 4));
            if ((e % 5) == 4) begin
                check("s1_reel0", int'(if1.reel0), (e - 3) % 8);
                check("s1_reel1", int'(if1.reel1), (e - 2) % 8);
                check("s1_reel2", int'(if1.reel2), (e - 1) % 8);
            end
        end
        spin_s[1] = 1'b0;
        rand1 = 1'b1;

        // Random traffic with occasional asynchronous resets.
        for (int c = 0; c < 800; c++) begin
            spin_s[0] = ($urandom_range(0, 3) == 0);
            rnd_s[0]  = 3'($urandom_range(0, 7));
            tick();
            if ($urandom_range(0, 99) == 0) begin
                #2 rst = 1'b0;
                #4 rst = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reel_controller.md
REEL_CONTROLLER -- requirements
Module: reel_controller

Interface
REQ-001 The block SHALL have parameter SPIN_CYCLES, default 8: clock edges each reel spins before stopping; legal range 1..255.
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: reset; asynchronous, active-low.
REQ-004 The block SHALL have port spin, input, 1: spin request, sampled on every rising clk edge.
REQ-005 The block SHALL have port rnd, input, 3: symbol from the upstream random-number stage, valid every cycle.
REQ-006 The block SHALL have ports reel0, reel1, reel2, each output, 3: displayed symbol per reel.
REQ-007 The block SHALL have port busy, output, 1: high while a spin is in progress.
REQ-008 The block SHALL have port done, output, 1: single-cycle pulse when a spin result is final.
REQ-009 The block SHALL have port result, output, 2: 0 = no match, 1 = pair (exactly two reels equal), 2 = triple; 3 is never driven.

Function
REQ-010 The block SHALL implement FSM states IDLE, SPIN0, SPIN1, SPIN2, EVAL, plus an 8-bit spin counter cnt.
REQ-011 In IDLE, spin=1 at an edge SHALL move to SPIN0, clear cnt, set busy=1 and clear result to 0 at that edge.
REQ-012 In SPINn, every edge SHALL load rnd into reel n and every higher-numbered reel; lower-numbered reels hold.
REQ-013 In SPINn, cnt SHALL increment each edge; when cnt == SPIN_CYCLES-1, reel n takes that edge's rnd as its final value, cnt clears, and the FSM advances (SPIN0->SPIN1->SPIN2->EVAL).
REQ-014 In EVAL, one edge SHALL register result from the three final reels, assert done for exactly one cycle, clear busy, and return to IDLE.
REQ-015 With the spin accepted at edge 0, reel0/reel1/reel2 SHALL freeze at edges S, 2S, 3S (S = SPIN_CYCLES), and done/result SHALL update at edge 3S+1.
REQ-016 spin SHALL be ignored in every state other than IDLE; no queuing.
REQ-017 spin held high continuously SHALL start a new spin on the first IDLE edge after done, i.e. back-to-back spins with done never overlapping busy.
REQ-018 In IDLE, reels and result SHALL hold their last values indefinitely.
REQ-019 SPIN_CYCLES = 1 SHALL give one edge per reel with no counter wrap error.

Reset
REQ-020 rst low SHALL immediately force state IDLE, cnt 0, reel0/1/2 0, busy 0, done 0, result 0, independent of clk.
REQ-021 Reset asserted mid-spin SHALL abort the spin; no done pulse follows, and the first spin after release behaves as from power-up.

Structure
REQ-022 Shared package slots_pkg SHALL hold SYM_W = 3, the FSM state type, and result encodings RES_NONE/RES_PAIR/RES_TRIPLE.
REQ-023 Match evaluation SHALL be a combinational sub-module reel_match (three 3-bit inputs, 2-bit result); the FSM, counter and reel registers stay in reel_controller.

Verification
REQ-024 S=4, rnd held 3'd5, spin pulse at edge 0 -> reels all 5, busy high edges 0..12, done pulse after edge 13, result=2.
REQ-025 S=4, rnd = 1 during edges 1..4, 2 during 5..8, 1 during 9..12 -> reels 1,2,1, result=1; repeat with 9..12 = 3 -> result=0.
REQ-026 spin pulsed at edges 3 and 10 of an active spin -> ignored; exactly one done, at edge 13.
REQ-027 rst low during SPIN1 (edge 6) -> all outputs 0 immediately, no done; new spin after release completes normally.
REQ-028 S=1, spin held high, rnd incrementing each cycle -> done every 5 edges, busy low only in the done cycle, reels equal to the rnd values at edges 1/2/3 of each spin.
